// File: rtl/cpu_bus_ctrl.sv
// rtl/cpu_bus_ctrl.sv - CPU bus responder: address decode, chip-selects and RD/WR strobes
module cpu_bus_ctrl #(
  parameter logic [7:0] IO_PAGE    = 8'h9F,
  parameter logic [1:0] ROM_PAGE   = 2'b11,
  parameter int         SRAM_BANKS = 32
) (
  input  logic        clk6x,
  input  logic        reset,
  input  logic        setup_cs,
  input  logic        release_wr,
  input  logic        release_cs,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_bank,
  input  logic        cpu_rwn,
  input  logic [4:0]  rom_bank,
  input  logic        err_clear,
  output logic [20:0] mem_ab,
  output logic        sram_csn,
  output logic        rom_csn,
  output logic        via_csn,
  output logic        nora_csn,
  output logic        mem_rdn,
  output logic        mem_wrn,
  output logic        busy,
  output logic        err_flag,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {IDLE, RD, WR, WRH} state_t;

  localparam logic [8:0] SRAM_LIM = 9'(SRAM_BANKS);

  state_t      state;
  state_t      state_nx;

  logic        dec_sram;
  logic        dec_rom;
  logic        dec_via;
  logic        dec_nora;
  logic        dec_mapped;
  logic [20:0] dec_ab;

  logic        sram_csn_nx;
  logic        rom_csn_nx;
  logic        via_csn_nx;
  logic        nora_csn_nx;
  logic        mem_rdn_nx;
  logic        mem_wrn_nx;
  logic [20:0] mem_ab_nx;
  logic        err_event;

  // Address decode of the live CPU bus; IO page wins over ROM, ROM over SRAM.
  // An unmapped access keeps the previous memory address on the bus.
  always_comb begin
    dec_sram = 1'b0;
    dec_rom  = 1'b0;
    dec_via  = 1'b0;
    dec_nora = 1'b0;
    dec_ab   = mem_ab;
    if (cpu_bank == 8'h00 && cpu_ab[15:8] == IO_PAGE) begin
      if (cpu_ab[7:5] == 3'b000) begin
        dec_via = 1'b1;
      end else begin
        dec_nora = 1'b1;
      end
      dec_ab = {13'b0, cpu_ab[7:0]};
    end else if (cpu_bank == 8'h00 && cpu_ab[15:14] == ROM_PAGE) begin
      dec_rom = 1'b1;
      dec_ab  = {2'b0, rom_bank, cpu_ab[13:0]};
    end else if ({1'b0, cpu_bank} < SRAM_LIM) begin
      dec_sram = 1'b1;
      dec_ab   = {cpu_bank[4:0], cpu_ab};
    end
  end

  assign dec_mapped = dec_sram | dec_rom | dec_via | dec_nora;

  // State register.
  always_ff @(posedge clk6x or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: a new setup always restarts the access, release_cs ends it,
  // release_wr only matters while the write strobe is on.
  always_comb begin
    state_nx = state;
    if (setup_cs) begin
      state_nx = (!cpu_rwn && dec_mapped) ? WR : RD;
    end else if (release_cs) begin
      state_nx = IDLE;
    end else if (release_wr && state == WR) begin
      state_nx = WRH;
    end
  end

  // Next values of the registered bus outputs and the protocol-error event.
  always_comb begin
    sram_csn_nx = sram_csn;
    rom_csn_nx  = rom_csn;
    via_csn_nx  = via_csn;
    nora_csn_nx = nora_csn;
    mem_rdn_nx  = mem_rdn;
    mem_wrn_nx  = mem_wrn;
    mem_ab_nx   = mem_ab;
    if (setup_cs) begin
      sram_csn_nx = ~dec_sram;
      rom_csn_nx  = ~dec_rom;
      via_csn_nx  = ~dec_via;
      nora_csn_nx = ~dec_nora;
      mem_rdn_nx  = ~(dec_mapped & cpu_rwn);
      mem_wrn_nx  = ~(dec_mapped & ~cpu_rwn);
      mem_ab_nx   = dec_ab;
    end else if (release_cs) begin
      sram_csn_nx = 1'b1;
      rom_csn_nx  = 1'b1;
      via_csn_nx  = 1'b1;
      nora_csn_nx = 1'b1;
      mem_rdn_nx  = 1'b1;
      mem_wrn_nx  = 1'b1;
    end else if (release_wr && state == WR) begin
      mem_wrn_nx = 1'b1;
    end

    err_event = 1'b0;
    if (release_cs && state == IDLE) begin
      err_event = 1'b1;
    end
    if (release_cs && state == WR && !release_wr) begin
      err_event = 1'b1;
    end
    if (setup_cs && state != IDLE && !release_cs) begin
      err_event = 1'b1;
    end
  end

  // Bus output registers; reset forces every select and strobe inactive at once.
  always_ff @(posedge clk6x or posedge reset) begin
    if (reset) begin
      sram_csn <= 1'b1;
      rom_csn  <= 1'b1;
      via_csn  <= 1'b1;
      nora_csn <= 1'b1;
      mem_rdn  <= 1'b1;
      mem_wrn  <= 1'b1;
      mem_ab   <= 21'd0;
      busy     <= 1'b0;
    end else begin
      sram_csn <= sram_csn_nx;
      rom_csn  <= rom_csn_nx;
      via_csn  <= via_csn_nx;
      nora_csn <= nora_csn_nx;
      mem_rdn  <= mem_rdn_nx;
      mem_wrn  <= mem_wrn_nx;
      mem_ab   <= mem_ab_nx;
      busy     <= (state_nx != IDLE);
    end
  end

  // Sticky error flag and saturating counter; clear takes priority over a new error.
  always_ff @(posedge clk6x or posedge reset) begin
    if (reset) begin
      err_flag <= 1'b0;
      err_cnt  <= 8'd0;
    end else if (err_clear) begin
      err_flag <= 1'b0;
      err_cnt  <= 8'd0;
    end else if (err_event) begin
      err_flag <= 1'b1;
      if (err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb/tb_cpu_bus_ctrl.sv - scoreboard bench for cpu_bus_ctrl against a behavioural model
module tb_cpu_bus_ctrl;

  logic        clk6x = 1'b0;
  logic        reset;
  logic        setup_cs;
  logic        release_wr;
  logic        release_cs;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_bank;
  logic        cpu_rwn;
  logic [4:0]  rom_bank;
  logic        err_clear;
  logic [20:0] mem_ab;
  logic        sram_csn;
  logic        rom_csn;
  logic        via_csn;
  logic        nora_csn;
  logic        mem_rdn;
  logic        mem_wrn;
  logic        busy;
  logic        err_flag;
  logic [7:0]  err_cnt;

  cpu_bus_ctrl dut (
    .clk6x      (clk6x),
    .reset      (reset),
    .setup_cs   (setup_cs),
    .release_wr (release_wr),
    .release_cs (release_cs),
    .cpu_ab     (cpu_ab),
    .cpu_bank   (cpu_bank),
    .cpu_rwn    (cpu_rwn),
    .rom_bank   (rom_bank),
    .err_clear  (err_clear),
    .mem_ab     (mem_ab),
    .sram_csn   (sram_csn),
    .rom_csn    (rom_csn),
    .via_csn    (via_csn),
    .nora_csn   (nora_csn),
    .mem_rdn    (mem_rdn),
    .mem_wrn    (mem_wrn),
    .busy       (busy),
    .err_flag   (err_flag),
    .err_cnt    (err_cnt)
  );

  always #5 clk6x = ~clk6x;

  // expected response of one clock edge; csn is {sram, rom, via, nora}
  typedef struct {
    logic [3:0] csn;
    logic       rdn;
    logic       wrn;
    logic       busy;
    logic       flag;
    int         cnt;
    int         ab;
    bit         ab_known;
    string      tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // model: phase 0 = no access, 1 = reading (or unmapped), 2 = write strobe on, 3 = write strobe off
  int         m_phase;
  logic [3:0] m_csn;
  logic       m_rdn;
  logic       m_wrn;
  logic       m_flag;
  int         m_cnt;
  int         m_ab;
  bit         m_ab_known;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    m_phase    = 0;
    m_csn      = 4'b1111;
    m_rdn      = 1'b1;
    m_wrn      = 1'b1;
    m_flag     = 1'b0;
    m_cnt      = 0;
    m_ab       = 0;
    m_ab_known = 1'b1;
  endtask

  // one clock of stimulus: drive at the falling edge, advance the model, queue the expectation
  task automatic cyc(input bit s, input bit rw, input bit rc, input bit clr,
                     input logic [7:0] bank, input logic [15:0] ab, input bit rwn,
                     input logic [4:0] rb, input string tag);
    int   b;
    int   a;
    int   addr;
    logic [3:0] sel;
    bit   err;
    exp_t e;
    @(negedge clk6x);
    setup_cs   = s;
    release_wr = rw;
    release_cs = rc;
    err_clear  = clr;
    cpu_bank   = bank;
    cpu_ab     = ab;
    cpu_rwn    = rwn;
    rom_bank   = rb;

    err = 1'b0;
    b = int'(bank);
    a = int'(ab);
    if (s) begin
      if (m_phase != 0 && !rc) err = 1'b1;
      if (m_phase == 0 && rc) err = 1'b1;
      sel  = 4'b0000;
      addr = 0;
      if (b == 0 && a / 256 == 'h9F) begin
        sel  = (a % 256 < 'h20) ? 4'b0010 : 4'b0001;
        addr = a % 256;
      end else if (b == 0 && a >= 'hC000) begin
        sel  = 4'b0100;
        addr = int'(rb) * 'h4000 + (a - 'hC000);
      end else if (b < 32) begin
        sel  = 4'b1000;
        addr = b * 65536 + a;
      end
      m_csn = ~sel;
      if (sel != 0) begin
        m_ab       = addr;
        m_ab_known = 1'b1;
        m_rdn      = !rwn;
        m_wrn      = rwn;
        m_phase    = rwn ? 1 : 2;
      end else begin
        m_ab_known = 1'b0;
        m_rdn      = 1'b1;
        m_wrn      = 1'b1;
        m_phase    = 1;
      end
    end else if (rc) begin
      if (m_phase == 0) err = 1'b1;
      if (m_phase == 2 && !rw) err = 1'b1;
      m_csn   = 4'b1111;
      m_rdn   = 1'b1;
      m_wrn   = 1'b1;
      m_phase = 0;
    end else if (rw && m_phase == 2) begin
      m_wrn   = 1'b1;
      m_phase = 3;
    end
    if (clr) begin
      m_flag = 1'b0;
      m_cnt  = 0;
    end else if (err) begin
      m_flag = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end

    e.csn      = m_csn;
    e.rdn      = m_rdn;
    e.wrn      = m_wrn;
    e.busy     = (m_phase != 0);
    e.flag     = m_flag;
    e.cnt      = m_cnt;
    e.ab       = m_ab;
    e.ab_known = m_ab_known;
    e.tag      = tag;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'h00, 16'h0000, 1'b1, 5'd0, "idle");
  endtask

  // monitor: compares the registered outputs just after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk6x);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, " csn"},  int'({sram_csn, rom_csn, via_csn, nora_csn}), int'(e.csn));
        chk({e.tag, " rdn"},  int'(mem_rdn), int'(e.rdn));
        chk({e.tag, " wrn"},  int'(mem_wrn), int'(e.wrn));
        chk({e.tag, " busy"}, int'(busy), int'(e.busy));
        chk({e.tag, " flag"}, int'(err_flag), int'(e.flag));
        chk({e.tag, " cnt"},  int'(err_cnt), e.cnt);
        if (e.ab_known) chk({e.tag, " mem_ab"}, int'(mem_ab), e.ab);
      end
    end
  end

  initial begin
    int bsel;
    logic [7:0]  rb8;
    logic [15:0] rab;
    bit s, rw, rc, clr, rwn;
    logic [7:0] banks [0:6];
    banks[0] = 8'h00; banks[1] = 8'h00; banks[2] = 8'h03; banks[3] = 8'h1F;
    banks[4] = 8'h20; banks[5] = 8'h40; banks[6] = 8'hFF;

    reset = 1'b1; setup_cs = 0; release_wr = 0; release_cs = 0; err_clear = 0;
    cpu_ab = 16'h0; cpu_bank = 8'h0; cpu_rwn = 1'b1; rom_bank = 5'd0;
    model_reset();
    #12;
    chk("reset csn", int'({sram_csn, rom_csn, via_csn, nora_csn}), 'hF);
    chk("reset strobes", int'({mem_rdn, mem_wrn}), 3);
    chk("reset busy", int'(busy), 0);
    chk("reset err", int'({err_flag, err_cnt}), 0);
    chk("reset mem_ab", int'(mem_ab), 0);
    @(negedge clk6x);
    reset = 1'b0;

    // SRAM read
    cyc(1, 0, 0, 0, 8'h03, 16'h1234, 1'b1, 5'd0, "sram_rd");
    idle(1);
    cyc(0, 0, 1, 0, 8'h00, 16'h0000, 1'b1, 5'd0, "sram_rel");
    idle(1);
    // VIA write with proper release sequence
    cyc(1, 0, 0, 0, 8'h00, 16'h9F05, 1'b0, 5'd0, "via_wr");
    cyc(0, 1, 0, 0, 8'h00, 16'h0000, 1'b1, 5'd0, "via_relwr");
    idle(1);
    cyc(0, 0, 1, 0, 8'h00, 16'h0000, 1'b1, 5'd0, "via_rel");
    // NORA register read, ROM read, unmapped write
    cyc(1, 0, 0, 0, 8'h00, 16'h9F40, 1'b1, 5'd0, "nora_rd");
    cyc(0, 0, 1, 0, 8'h00, 16'h0000, 1'b1, 5'd0, "nora_rel");
    cyc(1, 0, 0, 0, 8'h00, 16'hC123, 1'b1, 5'd5, "rom_rd");
    cyc(0, 0, 1, 0, 8'h00, 16'h0000, 1'b1, 5'd0, "rom_rel");
    cyc(1, 0, 0, 0, 8'h40, 16'h1234, 1'b0, 5'd0, "unmapped");
    cyc(0, 1, 0, 0, 8'h00, 16'h0000, 1'b1, 5'd0, "unm_relwr");
    cyc(0, 0, 1, 0, 8'h00, 16'h0000, 1'b1, 5'd0, "unm_rel");
    // back-to-back: new setup together with release_cs, then release_wr with release_cs
    cyc(1, 0, 0, 0, 8'h1F, 16'hFFFF, 1'b0, 5'd0, "b2b_a");
    cyc(1, 1, 1, 0, 8'h00, 16'h9F1F, 1'b0, 5'd0, "b2b_b");
    cyc(0, 1, 1, 0, 8'h00, 16'h0000, 1'b1, 5'd0, "wr_rel_both");
    // errors: release_cs in WR, setup while busy, saturation, clear
    cyc(1, 0, 0, 0, 8'h02, 16'h0100, 1'b0, 5'd0, "err_wr");
    cyc(0, 0, 1, 0, 8'h00, 16'h0000, 1'b1, 5'd0, "err_rel_wr");
    cyc(1, 0, 0, 0, 8'h02, 16'h0200, 1'b1, 5'd0, "err_s1");
    cyc(1, 0, 0, 0, 8'h00, 16'hE000, 1'b1, 5'd9, "err_s2");
    cyc(0, 0, 1, 0, 8'h00, 16'h0000, 1'b1, 5'd0, "err_rel");
    for (int i = 0; i < 300; i++) cyc(0, 0, 1, 0, 8'h00, 16'h0000, 1'b1, 5'd0, "sat");
    cyc(0, 0, 1, 1, 8'h00, 16'h0000, 1'b1, 5'd0, "clr_wins");
    cyc(0, 0, 1, 0, 8'h00, 16'h0000, 1'b1, 5'd0, "err_again");
    cyc(0, 0, 0, 1, 8'h00, 16'h0000, 1'b1, 5'd0, "clr");

    // asynchronous reset in the middle of a write
    cyc(1, 0, 0, 0, 8'h00, 16'h9F00, 1'b0, 5'd0, "pre_reset_wr");
    cyc(0, 0, 0, 0, 8'h00, 16'h0000, 1'b1, 5'd0, "pre_reset");
    @(posedge clk6x);
    #2;
    chk("pre-reset queue drained", q.size(), 0);
    reset = 1'b1;
    #1;
    chk("async reset csn", int'({sram_csn, rom_csn, via_csn, nora_csn}), 'hF);
    chk("async reset strobes", int'({mem_rdn, mem_wrn}), 3);
    chk("async reset busy", int'(busy), 0);
    reset = 1'b0;
    model_reset();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bsel = $urandom_range(0, 6);
      rb8  = banks[bsel];
      case ($urandom_range(0, 3))
        0: rab = {8'h9F, 8'($urandom_range(0, 255))};
        1: rab = {2'b11, 14'($urandom)};
        default: rab = 16'($urandom);
      endcase
      s   = ($urandom_range(0, 3) == 0);
      rw  = ($urandom_range(0, 2) == 0);
      rc  = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 40) == 0);
      rwn = $urandom_range(0, 1);
      if (s && rc && m_phase == 0) rc = 1'b0;
      if (s && rc && m_phase == 2) rw = 1'b1;
      cyc(s, rw, rc, clr, rb8, rab, rwn, 5'($urandom), "rand");
    end
    idle(2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk6x);
    #2;
    chk("scoreboard drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
